// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared defaults, derived sizes and FSM state type for the framebuffer
package fb_pkg;

  localparam int DEF_WIDTH        = 160;
  localparam int DEF_HEIGHT       = 120;
  localparam int DEF_BITSPERPIXEL = 8;
  localparam int DEF_COORD_W      = 8;

  localparam int PIX_COUNT = DEF_WIDTH * DEF_HEIGHT;
  localparam int ADDR_W    = $clog2(PIX_COUNT);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_t;

endpackage

// File: rtl/fb_clear_engine.sv
// rtl/fb_clear_engine.sv - clear FSM, pixel counter, fill colour, bank select and deferred swap
module fb_clear_engine
  import fb_pkg::*;
#(
  parameter int BITSPERPIXEL = DEF_BITSPERPIXEL,
  parameter int PIX          = PIX_COUNT,
  parameter int AW           = ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clear,
  input  logic [BITSPERPIXEL-1:0] i_clear_color,
  input  logic                    i_swap,
  output logic                    o_busy,
  output logic                    o_swap_pending,
  output logic                    o_front_sel,
  output logic                    o_we,
  output logic [AW-1:0]           o_addr,
  output logic [BITSPERPIXEL-1:0] o_data
);

  fb_state_t               r_state, w_state_nxt;
  logic [AW-1:0]           r_cnt, w_cnt_nxt;
  logic [BITSPERPIXEL-1:0] r_color, w_color_nxt;
  logic                    r_front, w_front_nxt;
  logic                    r_pend, w_pend_nxt;
  logic                    w_last;

  assign w_last = (r_cnt == AW'(PIX - 1));

  // Next-state logic: accept clear/swap in IDLE, walk the counter in CLEAR, apply a deferred swap on the final write
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_color_nxt = r_color;
    w_front_nxt = r_front;
    w_pend_nxt  = r_pend;
    case (r_state)
      IDLE: begin
        // Swap lands first, so a simultaneous clear fills the bank that was just on screen.
        if (i_swap) begin
          w_front_nxt = ~r_front;
        end
        if (i_clear) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
          w_color_nxt = i_clear_color;
        end
      end
      CLEAR: begin
        w_cnt_nxt = r_cnt + AW'(1);
        if (i_swap) begin
          w_pend_nxt = 1'b1;
        end
        if (w_last) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          if (r_pend || i_swap) begin
            w_front_nxt = ~r_front;
            w_pend_nxt  = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset abandons any clear in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_color <= '0;
      r_front <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_color <= w_color_nxt;
      r_front <= w_front_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  assign o_busy         = (r_state == CLEAR);
  assign o_swap_pending = r_pend;
  assign o_front_sel    = r_front;
  // A reset cycle must not commit the pixel the counter currently points at.
  assign o_we           = (r_state == CLEAR) && !rst;
  assign o_addr         = r_cnt;
  assign o_data         = r_color;

endmodule

// File: rtl/double_framebuffer.sv
// rtl/double_framebuffer.sv - two-bank pixel store with registered front-bank read and clear engine
module double_framebuffer
  import fb_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int HEIGHT       = DEF_HEIGHT,
  parameter int BITSPERPIXEL = DEF_BITSPERPIXEL,
  parameter int COORD_W      = DEF_COORD_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [COORD_W-1:0]      x,
  input  logic [COORD_W-1:0]      y,
  input  logic [BITSPERPIXEL-1:0] color,
  input  logic                    write,
  input  logic                    clear,
  input  logic [BITSPERPIXEL-1:0] clear_color,
  input  logic                    swap,
  input  logic [COORD_W-1:0]      x_data,
  input  logic [COORD_W-1:0]      y_data,
  output logic [BITSPERPIXEL-1:0] pixelData,
  output logic                    busy,
  output logic                    swap_pending,
  output logic                    front_sel
);

  localparam int N_PIX = WIDTH * HEIGHT;
  localparam int N_AW  = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  // y*WIDTH + x with y, WIDTH <= 2^COORD_W never exceeds this width.
  localparam int LIN_W = 2 * COORD_W + 1;
  localparam int CW1   = COORD_W + 1;

  logic [BITSPERPIXEL-1:0] r_mem [0:1][0:N_PIX-1];
  logic [BITSPERPIXEL-1:0] r_pix;

  logic                    w_busy, w_pend, w_front, w_back;
  logic                    w_clr_we;
  logic [N_AW-1:0]         w_clr_addr;
  logic [BITSPERPIXEL-1:0] w_clr_data;

  logic [LIN_W-1:0]        w_wr_lin, w_rd_lin;
  logic                    w_wr_ok, w_rd_ok;
  logic [N_AW-1:0]         w_wr_idx, w_rd_idx;

  fb_clear_engine #(
    .BITSPERPIXEL (BITSPERPIXEL),
    .PIX          (N_PIX),
    .AW           (N_AW)
  ) u_clear (
    .clk            (clk),
    .rst            (rst),
    .i_clear        (clear),
    .i_clear_color  (clear_color),
    .i_swap         (swap),
    .o_busy         (w_busy),
    .o_swap_pending (w_pend),
    .o_front_sel    (w_front),
    .o_we           (w_clr_we),
    .o_addr         (w_clr_addr),
    .o_data         (w_clr_data)
  );

  assign w_back = ~w_front;

  // Full-width linear addresses; the product is range-checked before being narrowed to a RAM index.
  assign w_wr_lin = LIN_W'(y) * LIN_W'(WIDTH) + LIN_W'(x);
  assign w_rd_lin = LIN_W'(y_data) * LIN_W'(WIDTH) + LIN_W'(x_data);

  assign w_wr_ok = ({1'b0, x} < CW1'(WIDTH)) && ({1'b0, y} < CW1'(HEIGHT))
                   && (w_wr_lin < LIN_W'(N_PIX));
  assign w_rd_ok = ({1'b0, x_data} < CW1'(WIDTH)) && ({1'b0, y_data} < CW1'(HEIGHT))
                   && (w_rd_lin < LIN_W'(N_PIX));

  assign w_wr_idx = w_wr_lin[N_AW-1:0];
  assign w_rd_idx = w_rd_lin[N_AW-1:0];

  // Single write port into the back bank: clear engine wins, drawing writes only when idle and in range
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_back][w_clr_addr] <= w_clr_data;
    end else if (write && !w_busy && w_wr_ok && !rst) begin
      r_mem[w_back][w_wr_idx] <= color;
    end
  end

  // Registered read of the front bank; out-of-range coordinates read as zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix <= '0;
    end else if (w_rd_ok) begin
      r_pix <= r_mem[w_front][w_rd_idx];
    end else begin
      r_pix <= '0;
    end
  end

  assign pixelData    = r_pix;
  assign busy         = w_busy;
  assign swap_pending = w_pend;
  assign front_sel    = w_front;

endmodule

// File: tb/tb_double_framebuffer.sv
// tb/tb_double_framebuffer.sv - directed self-checking bench for double_framebuffer
module tb_double_framebuffer;

  localparam int W   = 160;
  localparam int H   = 120;
  localparam int PIX = W * H;

  logic       clk;
  logic       rst;
  logic [7:0] x, y, color, clear_color, x_data, y_data;
  logic       write, clear, swap;
  logic [7:0] pixelData;
  logic       busy, swap_pending, front_sel;

  int checks = 0;
  int errors = 0;

  double_framebuffer dut (
    .clk          (clk),
    .rst          (rst),
    .x            (x),
    .y            (y),
    .color        (color),
    .write        (write),
    .clear        (clear),
    .clear_color  (clear_color),
    .swap         (swap),
    .x_data       (x_data),
    .y_data       (y_data),
    .pixelData    (pixelData),
    .busy         (busy),
    .swap_pending (swap_pending),
    .front_sel    (front_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input string tag, input int px, input int py, input logic [7:0] exp);
    x_data = 8'(px);
    y_data = 8'(py);
    step();
    check(tag, {24'h0, pixelData}, {24'h0, exp});
  endtask

  task automatic rd_addr(input string tag, input int a, input logic [7:0] exp);
    rd_check(tag, a % W, a / W, exp);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 30000) begin
      step();
      n++;
    end
    check(tag, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    int n;
    int bad;
    rst = 1'b1; x = '0; y = '0; color = '0; write = 1'b0; clear = 1'b0;
    clear_color = '0; swap = 1'b0; x_data = '0; y_data = '0;
    repeat (3) step();
    check("rst_busy",  {31'h0, busy},         32'h0);
    check("rst_front", {31'h0, front_sel},    32'h0);
    check("rst_pend",  {31'h0, swap_pending}, 32'h0);
    check("rst_pix",   {24'h0, pixelData},    32'h0);
    rst = 1'b0;

    // clear bank 1 with 0x11; writes and a second clear during busy must be ignored
    clear_color = 8'h11; clear = 1'b1;
    step();
    clear = 1'b0; clear_color = 8'hFF;
    write = 1'b1; x = 8'd5; y = 8'd5; color = 8'hEE;
    n = 0;
    while (busy === 1'b1 && n < 30000) begin
      if (n == 1000) begin clear = 1'b1; clear_color = 8'h99; end
      if (n == 1001) clear = 1'b0;
      if (n == 5000) begin x = 8'd159; y = 8'd119; end
      step();
      n++;
    end
    write = 1'b0;
    check("clear_len", n, PIX);
    check("clear_done", {31'h0, busy}, 32'h0);

    // dropped out-of-range write, then write together with swap lands in the presented bank
    write = 1'b1; x = 8'd200; y = 8'd10; color = 8'h77;
    step();
    x = 8'd3; y = 8'd2; color = 8'h5A; swap = 1'b1;
    step();
    write = 1'b0; swap = 1'b0;
    check("swap_idle_front", {31'h0, front_sel}, 32'h1);
    rd_check("px_3_2", 3, 2, 8'h5A);
    rd_check("oor_x", 160, 0, 8'h00);
    rd_check("oor_y", 0, 120, 8'h00);
    rd_check("wrap_40_11", 40, 11, 8'h11);
    rd_check("busy_wr_5_5", 5, 5, 8'h11);
    rd_check("busy_wr_last", 159, 119, 8'h11);
    for (int i = 0; i < W; i++) rd_check("row10", i, 10, 8'h11);
    for (int a = 0; a < PIX; a += 97) rd_addr("scan_11", a, (a == 323) ? 8'h5A : 8'h11);

    // swap issued mid-clear is deferred to the edge where busy falls
    clear_color = 8'h33; clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (99) step();
    swap = 1'b1;
    step();
    swap = 1'b0;
    check("pend_set", {31'h0, swap_pending}, 32'h1);
    check("pend_front", {31'h0, front_sel}, 32'h1);
    swap = 1'b1;
    repeat (2) step();
    swap = 1'b0;
    n = 0; bad = 0;
    while (busy === 1'b1 && n < 30000) begin
      if (front_sel !== 1'b1) bad++;
      step();
      n++;
    end
    check("pend_busy_fall", {31'h0, busy}, 32'h0);
    check("pend_front_held", bad, 0);
    check("pend_toggle", {31'h0, front_sel}, 32'h0);
    check("pend_clr", {31'h0, swap_pending}, 32'h0);
    repeat (3) step();
    check("one_toggle", {31'h0, front_sel}, 32'h0);

    // present and clear: swap+clear together, display shows former back bank at once
    x_data = 8'd3; y_data = 8'd2;
    swap = 1'b1; clear = 1'b1; clear_color = 8'h22;
    step();
    swap = 1'b0; clear = 1'b0;
    check("pc_front", {31'h0, front_sel}, 32'h1);
    check("pc_busy", {31'h0, busy}, 32'h1);
    check("pc_old_front", {24'h0, pixelData}, 32'h33);
    step();
    check("pc_new_front", {24'h0, pixelData}, 32'h5A);
    wait_idle("pc_done");
    swap = 1'b1;
    step();
    swap = 1'b0;
    check("pc_swap_back", {31'h0, front_sel}, 32'h0);
    for (int a = 0; a < PIX; a += 97) rd_addr("scan_22", a, 8'h22);
    rd_addr("scan_22_last", PIX - 1, 8'h22);

    // reset when the counter reaches 5000 leaves a partial fill of bank 1
    clear_color = 8'h44; clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (5000) step();
    rst = 1'b1;
    step();
    check("abort_busy",  {31'h0, busy},         32'h0);
    check("abort_front", {31'h0, front_sel},    32'h0);
    check("abort_pend",  {31'h0, swap_pending}, 32'h0);
    check("abort_pix",   {24'h0, pixelData},    32'h0);
    rst = 1'b0;
    swap = 1'b1;
    step();
    swap = 1'b0;
    check("abort_swap", {31'h0, front_sel}, 32'h1);
    rd_addr("abort_a0", 0, 8'h44);
    rd_addr("abort_a4999", 4999, 8'h44);
    rd_addr("abort_a5000", 5000, 8'h11);
    rd_addr("abort_alast", PIX - 1, 8'h11);
    for (int a = 0; a < PIX; a += 97) rd_addr("scan_abort", a, (a < 5000) ? 8'h44 : 8'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/double_framebuffer.md
# double_framebuffer

Parametrised double-buffered pixel store between the drawing unit and the video output. The drawing side writes pixels into the back bank while the scan-out side reads the front bank through a registered read port. A swap request exchanges the banks. A built-in clear engine fills the back bank with a colour at one pixel per cycle.

## Interface
Parameters:
- WIDTH, 160, pixels per line.
- HEIGHT, 120, lines per frame.
- BITSPERPIXEL, 8, colour width.
- COORD_W, 8, coordinate width. Must satisfy WIDTH ≤ 2^COORD_W and HEIGHT ≤ 2^COORD_W.

Ports:
- clk  in  1  sole clock. All logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- x, y  in  COORD_W  write coordinate, back bank.
- color  in  BITSPERPIXEL  write data.
- write  in  1  write strobe.
- clear  in  1  request fill of the back bank.
- clear_color  in  BITSPERPIXEL  fill colour, sampled when clear is accepted.
- swap  in  1  request bank exchange.
- x_data, y_data  in  COORD_W  read coordinate, front bank.
- pixelData  out  BITSPERPIXEL  registered read data.
- busy  out  1  clear engine active.
- swap_pending  out  1  swap requested but not yet applied.
- front_sel  out  1  index of the bank currently shown.

## Operation
- Storage: 2*WIDTH*HEIGHT words. Address = {bank, y*WIDTH + x}, with the row stride equal to WIDTH. Back bank = ~front_sel.
- Write: if write=1, busy=0, x<WIDTH and y<HEIGHT, store color at the back-bank address.
  - Out-of-range writes are dropped.
  - Writes while busy=1 are dropped.
- Read: every cycle, sample x_data and y_data and read the front bank.
  - Out-of-range coordinates return 0.
- FSM states:
  - IDLE → CLEAR on clear=1: latch clear_color, set the pixel counter to 0.
  - CLEAR: write the latched colour to the back bank at address counter, then increment the counter.
  - CLEAR → IDLE after the write of address WIDTH*HEIGHT-1.
  - busy = (state==CLEAR).
- clear=1 while in CLEAR is ignored; there is no restart.
- Swap in IDLE: front_sel toggles at the end of the cycle.
- Swap in CLEAR: set swap_pending. When the clear completes, front_sel toggles on the same edge the FSM returns to IDLE, and swap_pending is cleared.
- Further swap requests while pending are absorbed; one toggle per pending flag.
- swap=1 and clear=1 together in IDLE:
  - Swap applies first.
  - The clear targets the new back bank (the previous front): "present and clear".
- write=1 and swap=1 together in IDLE: the write lands in the pre-swap back bank, i.e. the bank being presented.
- Reset:
  - state=IDLE, counter=0, front_sel=0, swap_pending=0, busy=0, pixelData=0.
  - A clear in progress is aborted; the back bank is left partially filled.
  - Memory contents are not reset.

## Timing
- Read latency is 1 cycle: pixelData at edge N+1 reflects x_data and y_data at edge N, using front_sel as it was before edge N.
- Write latency is 1 cycle; storage is visible to a read of the same bank on the next cycle.
- A swap issued in IDLE at edge N changes which bank is read from cycle N+1 onward.
- Clear accepted at edge N:
  - busy=1 during cycles N+1 … N+WIDTH*HEIGHT.
  - busy=0 from cycle N+WIDTH*HEIGHT+1.
  - Exactly WIDTH*HEIGHT writes.
- Counter width is $clog2(WIDTH*HEIGHT). Address multiply is computed at the full product width, with no truncation before the range check.
- The read and write paths use separate ports (simple dual-port RAM); the clear engine shares the write port.

## Structure
- Shared package fb_pkg: default WIDTH, HEIGHT, BITSPERPIXEL, COORD_W, the derived PIX_COUNT and ADDR_W, and the FSM state enum (IDLE, CLEAR).
- One sub-module, fb_clear_engine, holds the FSM, counter, latched colour and swap_pending logic. It outputs a write request, address and data to the top-level write mux.
- The top level holds the RAM, the address computation, the write arbitration and the read register.

## Test plan
- Reset, then write (x=3, y=2, color=0x5A), swap, read (3,2) → pixelData=0x5A one cycle after the read address; front_sel=1.
- Read (160,0) and (0,120) → pixelData=0x00. Write to (200,10) → no RAM change; verify by reading (200-160-ish neighbours) and all of row 10 unchanged.
- clear with clear_color=0x11 → busy high for exactly 19200 cycles. After swap, all pixels read 0x11. Writes issued during busy leave no trace.
- swap issued 100 cycles into a clear → swap_pending=1 and front_sel unchanged until the final clear write. front_sel toggles on the same edge busy falls.
- swap and clear (0x22) in the same cycle, with the front bank showing 0x5A → display immediately shows the former back bank, and the former front bank becomes all 0x22.
- rst asserted mid-clear at count 5000 → next cycle busy=0, front_sel=0, pixelData=0. Addresses 0–4999 hold the clear colour; address 5000 and above are unchanged.
